// File: rtl/sync_fifo_if.sv
// Handshake/status bundle for sync_fifo; overflow/underflow exist only when SYNC_FIFO_ERR_EN is defined.
interface sync_fifo_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 3
);
  logic              wr;
  logic              rd;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic              almost_empty;
  logic              almost_full;
  logic [ADDR_W:0]   count;
`ifdef SYNC_FIFO_ERR_EN
  logic              overflow;
  logic              underflow;
`endif

  modport master (
    output wr, rd, din,
    input  dout, empty, full, almost_empty, almost_full, count
`ifdef SYNC_FIFO_ERR_EN
    , input overflow, underflow
`endif
  );

  modport slave (
    input  wr, rd, din,
    output dout, empty, full, almost_empty, almost_full, count
`ifdef SYNC_FIFO_ERR_EN
    , output overflow, underflow
`endif
  );
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and registered status flags.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow flags.
module sync_fifo #(
  parameter int unsigned DATA_W    = 4,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned AFULL_TH  = 6,
  parameter int unsigned AEMPTY_TH = 2
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_if.slave     bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  count_q;
  logic [DATA_W-1:0] dout_q;
  logic              empty_q;
  logic              full_q;
  logic              aempty_q;
  logic              afull_q;

  logic              wr_ok;
  logic              rd_ok;
  logic [PTR_W-1:0]  wptr_n;
  logic [PTR_W-1:0]  rptr_n;
  logic [PTR_W-1:0]  count_n;

  // Acceptance uses the flags registered before this edge.
  always_comb begin
    wr_ok   = bus.wr && !full_q;
    rd_ok   = bus.rd && !empty_q;
    wptr_n  = wptr + PTR_W'(wr_ok);
    rptr_n  = rptr + PTR_W'(rd_ok);
    count_n = wptr_n - rptr_n;
  end

  // Storage is never reset; writes are suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wptr[ADDR_W-1:0]] <= bus.din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
    end else begin
      wptr     <= wptr_n;
      rptr     <= rptr_n;
      count_q  <= count_n;
      empty_q  <= (wptr_n == rptr_n);
      full_q   <= (wptr_n[ADDR_W] != rptr_n[ADDR_W]) &&
                  (wptr_n[ADDR_W-1:0] == rptr_n[ADDR_W-1:0]);
      aempty_q <= (count_n <= PTR_W'(AEMPTY_TH));
      afull_q  <= (count_n >= PTR_W'(AFULL_TH));
      if (rd_ok) begin
        dout_q <= mem[rptr[ADDR_W-1:0]];
      end
    end
  end

  assign bus.dout         = dout_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.count        = count_q;

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q;
  logic unf_q;

  // Sticky: set on any rejected request, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_q | (bus.wr & full_q);
      unf_q <= unf_q | (bus.rd & empty_q);
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`endif
endmodule
